float_to_fixed_iter: RTL

Iterative IEEE-754 single-precision to signed 32-bit fixed-point converter. It is the return path of the fixed/float conversion datapath: it takes floats of the form produced by the fixed-to-float stage and converts them back to two's-complement fixed point with a runtime binary-point position. A one-bit-per-cycle shifter FSM keeps area small. Valid/ready handshakes are used on both sides.

---
 rtl/float_to_fixed_iter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/float_to_fixed_iter.sv
// Iterative IEEE-754 single -> signed 32-bit fixed-point converter, one shift per cycle.
// Define FTF_SATURATE_EN to saturate overflow/Inf/NaN results by sign instead of 0x80000000.
module float_to_fixed_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_in,
    input  logic [4:0]  fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fixed_out,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic        left_q, left_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] fixed_q, fixed_d;
    logic        ovf_q, ovf_d;

    logic [7:0]        in_exp;
    logic [22:0]       in_man;
    logic              in_sign;
    logic signed [9:0] s_w;
    logic [4:0]        s_neg;
    logic [4:0]        cnt_calc;
    logic              ovf_calc;
    logic [31:0]       sat_val;

    assign in_sign = float_in[31];
    assign in_exp  = float_in[30:23];
    assign in_man  = float_in[22:0];

    // Left-shift count relative to the integer LSB; range -149..135 for finite inputs.
    assign s_w   = $signed({2'b00, in_exp}) + $signed({5'b00000, fixpointpos}) - 10'sd150;
    // |s| <= 24 whenever it is used, so 5-bit negation is exact.
    assign s_neg = 5'd0 - s_w[4:0];

    always_comb begin
        cnt_calc = s_w[4:0];
        if (s_w < 0)
            cnt_calc = (s_w < -10'sd24) ? 5'd24 : s_neg;
    end

    // s == 8 only fits for exactly -2^31.
    assign ovf_calc = (in_exp == 8'hFF) || (s_w > 10'sd8) ||
                      ((s_w == 10'sd8) && (!in_sign || (in_man != 23'd0)));

`ifdef FTF_SATURATE_EN
    assign sat_val = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    assign sat_val = 32'h8000_0000;
`endif

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        left_d  = left_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        fixed_d = fixed_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    mag_d  = {8'd0, 1'b1, in_man};
                    left_d = !s_w[9];
                    if (in_exp == 8'd0) begin
                        fixed_d = 32'd0;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (ovf_calc) begin
                        fixed_d = sat_val;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_calc;
                        state_d = (cnt_calc != 5'd0) ? SHIFT : NEG;
                    end
                end
            end
            SHIFT: begin
                mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_d = NEG;
            end
            NEG: begin
                fixed_d = sign_q ? (32'd0 - mag_q) : mag_q;
                ovf_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            left_q  <= 1'b0;
            mag_q   <= 32'd0;
            cnt_q   <= 5'd0;
            fixed_q <= 32'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            left_q  <= left_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            fixed_q <= fixed_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign fixed_out = fixed_q;
    assign overflow  = ovf_q;

endmodule
